gate_truth_checker: RTL
=======================

# gate_truth_checker

Self-checking stimulus/response stage for 2-input combinational gates. It sits directly upstream and downstream of a gate under test, such as `and_gate`: it drives `a`/`b` through all four input vectors, samples the gate output after a settle interval, and compares each sample against a parameterised truth table. Results are a per-vector mismatch mask and a single pass flag, delivered with a start/done handshake.

## Interface
- `TRUTH_TABLE`, default 4'b1000: expected output per vector; bit k = expected `c` for {a,b} = k (4'b1000 = AND).
- `SETTLE`, default 2: cycles each vector is held before `c_in` is sampled; legal range 1..15.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request, sampled only in IDLE.
- `a_out`  out  1  drives gate input `a`.
- `b_out`  out  1  drives gate input `b`.
- `c_in`  in  1  gate output, same clock domain, combinational from `a_out`/`b_out`.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the last completed run had no mismatches.
- `observed`  out  4  captured `c_in` per vector, bit k for vector k.
- `fail_mask`  out  4  bit k = `observed[k]` XOR `TRUTH_TABLE[k]`.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs are 0: `a_out`, `b_out`, `busy`, `done`, `pass`, `observed`, `fail_mask`.
  - FSM is in IDLE; vector index = 0; settle counter = 0.
- Vector order: index k = 0,1,2,3 maps to {a_out,b_out} = 00, 01, 10, 11.
- FSM states: IDLE and RUN.
- IDLE, `start` = 1 at an edge:
  - Go to RUN and set `busy` to 1.
  - Set index to 0 and drive {a_out,b_out} = 00.
  - Clear counter, `observed`, `fail_mask` and `pass`.
- IDLE, `start` = 0: all outputs hold, except `done`, which is 0.
- RUN:
  - The counter increments every cycle.
  - When counter = SETTLE-1 at an edge:
    - Capture `c_in` into `observed[k]`.
    - Set `fail_mask[k]` = `c_in` ^ `TRUTH_TABLE[k]`.
    - Clear the counter.
    - If k < 3, advance the index and drive vector k+1 on that same edge.
  - When that sampling edge is for k = 3:
    - Go to IDLE and drive {a_out,b_out} = 00.
    - Set `busy` to 0 and pulse `done` to 1.
    - Set `pass` = (final `fail_mask` == 0), including the bit captured on this edge.
- `start` during RUN is ignored; no queuing.
- Results (`observed`, `fail_mask`, `pass`) hold until the next accepted `start` or reset.
- Reset asserted mid-run:
  - All outputs and state return to reset values immediately.
  - No `done` pulse is produced.
  - Partial results are discarded.

## Timing
- E0 is the edge at which `start` is accepted.
- Vector k is driven from edge E0 + k·SETTLE.
- `c_in` for vector k is sampled at edge E0 + (k+1)·SETTLE.
- `done` is high for the single cycle following edge E0 + 4·SETTLE. Run latency is 4·SETTLE cycles.
- `busy` is high from E0 up to E0 + 4·SETTLE.
- `start` held high continuously:
  - The next run is accepted at E0 + 4·SETTLE + 1, the cycle `done` is high.
  - Runs repeat every 4·SETTLE + 1 cycles.
- SETTLE = 1: `c_in` is sampled one edge after each vector is driven. This is legal because the gate under test is combinational.
- No combinational path from `start` or `c_in` to any output; all outputs are registered.

## Test plan
- Reset check: hold `rst_n` = 0 with `start` = 1 → all outputs remain 0 and `busy` stays 0.
- Good AND gate, TRUTH_TABLE = 4'b1000, SETTLE = 2, one-cycle `start` → expected response:
  - `a_out`/`b_out` step 00, 01, 10, 11, two cycles each.
  - `done` pulses 8 cycles after E0.
  - `observed` = 4'b1000, `fail_mask` = 0, `pass` = 1.
- Wrong gate (OR) with TRUTH_TABLE = 4'b1000 → `observed` = 4'b1110, `fail_mask` = 4'b0110, `pass` = 0.
- Extra `start` pulses at E0+3 and E0+5 with SETTLE = 2 → ignored; single `done` at E0+8.
- `start` held high continuously with SETTLE = 2 → `done` pulses every 9 cycles; `busy` is low for exactly one cycle between runs.
- Reset mid-run, `rst_n` low at E0+3 → outputs go to 0 immediately and no `done` appears. A subsequent `start` completes normally with `pass` = 1.

Source files
------------

// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between gate_truth_checker and the gate it exercises.
// The checker is the master; the gate-under-test side (and its driver of start) is the slave.
interface gate_truth_checker_if;
    logic       start;
    logic       a_out;
    logic       b_out;
    logic       c_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] observed;
    logic [3:0] fail_mask;

    modport master (
        input  start,
        input  c_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output observed,
        output fail_mask
    );

    modport slave (
        output start,
        output c_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  observed,
        input  fail_mask
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through all four input vectors, samples its output after a
// settle interval and compares each sample against TRUTH_TABLE; all outputs registered.
module gate_truth_checker #(
    parameter logic [3:0]  TRUTH_TABLE = 4'b1000,
    parameter int unsigned SETTLE      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.master bus
);

    localparam logic [3:0] LAST_COUNT = 4'(SETTLE - 1);
    localparam logic [1:0] LAST_INDEX = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] idx_r;
    logic [1:0] idx_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       a_r;
    logic       a_s;
    logic       b_r;
    logic       b_s;
    logic       busy_r;
    logic       busy_s;
    logic       done_r;
    logic       done_s;
    logic       pass_r;
    logic       pass_s;
    logic [3:0] observed_r;
    logic [3:0] observed_s;
    logic [3:0] fail_mask_r;
    logic [3:0] fail_mask_s;

    function automatic logic [3:0] set_bit(input logic [3:0] mask,
                                           input logic [1:0] idx,
                                           input logic       value);
        logic [3:0] result;
        result      = mask;
        result[idx] = value;
        return result;
    endfunction

    function automatic logic mismatch_bit(input logic [1:0] idx, input logic sample);
        return sample ^ TRUTH_TABLE[idx];
    endfunction

    function automatic logic all_clear(input logic [3:0] mask);
        return ~(|mask);
    endfunction

    // Next-state and next-output computation for the two-state sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        a_s         = a_r;
        b_s         = b_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        pass_s      = pass_r;
        observed_s  = observed_r;
        fail_mask_s = fail_mask_r;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s     = RUN;
                    busy_s      = 1'b1;
                    idx_s       = 2'd0;
                    cnt_s       = 4'd0;
                    a_s         = 1'b0;
                    b_s         = 1'b0;
                    pass_s      = 1'b0;
                    observed_s  = 4'b0000;
                    fail_mask_s = 4'b0000;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_COUNT) begin
                    observed_s  = set_bit(observed_r, idx_r, bus.c_in);
                    fail_mask_s = set_bit(fail_mask_r, idx_r, mismatch_bit(idx_r, bus.c_in));
                    cnt_s       = 4'd0;
                    if (idx_r != LAST_INDEX) begin
                        // Next vector goes out on the same edge that samples this one.
                        idx_s      = idx_r + 2'd1;
                        {a_s, b_s} = idx_r + 2'd1;
                    end else begin
                        state_s = IDLE;
                        idx_s   = 2'd0;
                        a_s     = 1'b0;
                        b_s     = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = all_clear(fail_mask_s);
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                idx_s       = 2'd0;
                cnt_s       = 4'd0;
                a_s         = 1'b0;
                b_s         = 1'b0;
                busy_s      = 1'b0;
                pass_s      = 1'b0;
                observed_s  = 4'b0000;
                fail_mask_s = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset clears everything, discarding partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            cnt_r       <= 4'd0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            observed_r  <= 4'b0000;
            fail_mask_r <= 4'b0000;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            a_r         <= a_s;
            b_r         <= b_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            observed_r  <= observed_s;
            fail_mask_r <= fail_mask_s;
        end
    end

    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.observed  = observed_r;
    assign bus.fail_mask = fail_mask_r;

endmodule
